pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Program-counter generator for the rv32i fetch stage. Supersedes the combinational PC incrementer.
- Holds the architectural PC in a register and advances it by a parametrised increment.
- Applies stall, branch/jump redirect, trap entry and trap return with fixed priority.
- Flags misaligned redirect targets and provides a small run/halt state machine so fetch knows when the PC is valid.

Parameters:
- DWIDTH, 32, PC width in bits (8..64).
- INC, 4, increment per advance; must be a power of two ≥ 1.
- RESET_VEC, 32'h0000_0000, PC value loaded by reset (DWIDTH wide).
- ALIGN_BITS, 2, number of low target bits that must be zero; 0 disables the misalignment check.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset; synchronous, active-low
- stall  input  1  hold PC (pipeline stall)
- halt_req  input  1  request to enter HALT
- resume  input  1  leave HALT
- branch_taken  input  1  conditional branch resolved taken
- branch_target  input  DWIDTH  branch destination
- jump  input  1  JAL/JALR redirect
- jump_target  input  DWIDTH  jump destination
- trap  input  1  exception/interrupt entry
- trap_vec  input  DWIDTH  trap handler address (mtvec)
- mret  input  1  trap return
- epc  input  DWIDTH  return address (mepc)
- pc  output  DWIDTH  current PC (registered)
- pc_next_seq  output  DWIDTH  pc + INC, combinational, wraps modulo 2^DWIDTH
- pc_valid  output  1  pc is fetchable this cycle
- redirect  output  1  registered; PC was loaded from a non-sequential source last edge
- misaligned  output  1  registered one-cycle pulse: rejected misaligned target
- bad_addr  output  DWIDTH  the rejected target; holds until the next rejection

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - pc=RESET_VEC, state=BOOT, pc_valid=0, redirect=0, misaligned=0, bad_addr=0.
  - Reset asserted mid-operation overrides every other input on that edge.
- States:
  - BOOT: pc_valid=0. Always goes to RUN on the next edge; pc is unchanged.
  - RUN: pc_valid=1. PC updates per the priority list below.
  - HALT: pc_valid=0; pc held. Entered from RUN when halt_req=1 and no redirect source is active on that edge. Left to RUN when resume=1 or trap=1.
  - trap in HALT: pc loads trap_vec on the same edge.
- Priority in RUN, evaluated each edge (first match wins):
  1. trap: pc ← trap_vec. trap_vec is never checked for alignment.
  2. mret: pc ← epc.
  3. jump: pc ← jump_target.
  4. branch_taken: pc ← branch_target.
  5. stall or halt_req: pc held.
  6. Otherwise: pc ← pc + INC.
- Redirect rules:
  - Redirects (items 2–4) override stall.
  - redirect=1 for one cycle after any load from items 1–4.
- Alignment:
  - For items 2–4, a target with target[ALIGN_BITS-1:0] ≠ 0 is rejected.
  - On rejection: pc held, misaligned=1 for the next cycle, bad_addr=target, redirect=0.
  - The core is expected to raise trap in response.
- Arithmetic: the increment wraps; all-ones minus INC+1 plus INC gives 0, with no flag.
- Latency:
  - pc reflects the inputs one edge after they are sampled.
  - pc_next_seq has zero latency from pc.

Decomposition:
- Package pc_pkg holds:
  - state enum {BOOT, RUN, HALT};
  - localparam for the default RESET_VEC;
  - the redirect-source priority encoding as an enum {SRC_TRAP, SRC_MRET, SRC_JUMP, SRC_BRANCH, SRC_HOLD, SRC_SEQ}.
- One sub-module, pc_inc: the parametrised combinational pc + INC adder. It is reused for pc_next_seq.

Test Plan:
- Reset sequence: rst_n=0 for 2 cycles with RESET_VEC=0, then release. Expect pc=0, pc_valid=0 for 1 cycle, then pc=0,4,8,12 with pc_valid=1.
- Stall versus branch: at pc=8, stall=1 for 3 cycles gives pc stuck at 8. Then stall=1 with branch_taken=1, target=0x40 gives pc=0x40 and redirect=1 for one cycle.
- Priority: trap (vec 0x100), mret (epc 0x200) and jump (0x300) all asserted together. Expect pc=0x100.
- Misaligned jump to 0x42: pc held, misaligned=1 for one cycle, bad_addr=0x42. A following trap to 0x80 gives pc=0x80.
- Wrap-around with DWIDTH=8, RESET_VEC=8'hF8, INC=4: pc sequence 0xF8, 0xFC, 0x00, 0x04.
- Halt: halt_req=1 at pc=0x10 gives pc_valid=0 and pc held at 0x10. resume=1 gives pc_valid=1 and pc=0x14 one cycle later. Asserting rst_n=0 while in HALT gives pc=RESET_VEC and state BOOT.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the fetch-stage PC generator.
//   state_t - run/halt state machine encoding (BOOT, RUN, HALT)
//   src_t   - PC load source, listed in priority order (first wins)
//   DEFAULT_RESET_VEC - reset PC used when the instance does not override it
package pc_pkg;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      SRC_TRAP   = 3'd0,
      SRC_MRET   = 3'd1,
      SRC_JUMP   = 3'd2,
      SRC_BRANCH = 3'd3,
      SRC_HOLD   = 3'd4,
      SRC_SEQ    = 3'd5
   } src_t;

endpackage

// File: rtl/pc_inc.sv
// pc_inc: combinational sequential-PC adder, sum = addr + INC.
//   addr - current PC (DWIDTH)
//   sum  - addr + INC, wrapping modulo 2^DWIDTH (carry out is discarded)
module pc_inc #(
   parameter int DWIDTH = 32,
   parameter int INC    = 4
) (
   input  logic [DWIDTH-1:0] addr,
   output logic [DWIDTH-1:0] sum
);

   localparam logic [DWIDTH-1:0] INC_VAL = DWIDTH'(INC);

   assign sum = addr + INC_VAL;

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the rv32i fetch stage.
// Holds the architectural PC and advances it by INC, with fixed-priority
// trap / mret / jump / branch / stall handling, misaligned-target rejection
// and a BOOT/RUN/HALT state machine that tells fetch when pc is valid.
//   clk, rst_n           - clock and synchronous active-low reset
//   stall, halt_req      - hold PC / request HALT
//   resume               - leave HALT
//   branch_taken/_target - taken branch redirect
//   jump/jump_target     - JAL/JALR redirect
//   trap/trap_vec        - exception/interrupt entry (never alignment-checked)
//   mret/epc             - trap return
//   pc                   - registered current PC
//   pc_next_seq          - pc + INC, combinational
//   pc_valid             - pc is fetchable (state RUN)
//   redirect             - last edge loaded pc from a non-sequential source
//   misaligned           - one-cycle pulse: last edge rejected a target
//   bad_addr             - most recently rejected target
module pc_gen
   import pc_pkg::*;
#(
   parameter int                DWIDTH     = 32,
   parameter int                INC        = 4,
   parameter logic [DWIDTH-1:0] RESET_VEC  = DWIDTH'(DEFAULT_RESET_VEC),
   parameter int                ALIGN_BITS = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              halt_req,
   input  logic              resume,
   input  logic              branch_taken,
   input  logic [DWIDTH-1:0] branch_target,
   input  logic              jump,
   input  logic [DWIDTH-1:0] jump_target,
   input  logic              trap,
   input  logic [DWIDTH-1:0] trap_vec,
   input  logic              mret,
   input  logic [DWIDTH-1:0] epc,
   output logic [DWIDTH-1:0] pc,
   output logic [DWIDTH-1:0] pc_next_seq,
   output logic              pc_valid,
   output logic              redirect,
   output logic              misaligned,
   output logic [DWIDTH-1:0] bad_addr
);

   // Mask of low target bits that must be zero; ALIGN_BITS=0 yields an
   // all-zero mask, which disables the check without a zero-width slice.
   localparam logic [DWIDTH-1:0] ALIGN_MASK = DWIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

   state_t            state_reg, state_next;
   logic [DWIDTH-1:0] pc_reg, pc_next;
   logic              redirect_reg, redirect_next;
   logic              misaligned_reg, misaligned_next;
   logic [DWIDTH-1:0] bad_addr_reg, bad_addr_next;

   logic [DWIDTH-1:0] pc_plus_inc;
   src_t              src;
   logic [DWIDTH-1:0] redir_target;
   logic              target_misaligned;
   logic              redirect_active;

   pc_inc #(
      .DWIDTH (DWIDTH),
      .INC    (INC)
   ) u_inc (
      .addr (pc_reg),
      .sum  (pc_plus_inc)
   );

   // Priority encoder for the PC load source.
   always_comb begin
      src = SRC_SEQ;
      if (trap)
         src = SRC_TRAP;
      else if (mret)
         src = SRC_MRET;
      else if (jump)
         src = SRC_JUMP;
      else if (branch_taken)
         src = SRC_BRANCH;
      else if (stall || halt_req)
         src = SRC_HOLD;
   end

   // Target of the checked redirect sources (mret/jump/branch) only.
   always_comb begin
      redir_target = '0;
      case (src)
         SRC_MRET:   redir_target = epc;
         SRC_JUMP:   redir_target = jump_target;
         SRC_BRANCH: redir_target = branch_target;
         default:    redir_target = '0;
      endcase
   end

   assign target_misaligned = |(redir_target & ALIGN_MASK);
   assign redirect_active   = trap || mret || jump || branch_taken;

   always_comb begin
      state_next      = state_reg;
      pc_next         = pc_reg;
      redirect_next   = 1'b0;
      misaligned_next = 1'b0;
      bad_addr_next   = bad_addr_reg;

      case (state_reg)
         BOOT: begin
            state_next = RUN;
         end

         RUN: begin
            case (src)
               SRC_TRAP: begin
                  pc_next       = trap_vec;
                  redirect_next = 1'b1;
               end
               SRC_MRET, SRC_JUMP, SRC_BRANCH: begin
                  if (target_misaligned) begin
                     // Hold pc and report; the core answers with a trap.
                     misaligned_next = 1'b1;
                     bad_addr_next   = redir_target;
                  end else begin
                     pc_next       = redir_target;
                     redirect_next = 1'b1;
                  end
               end
               SRC_HOLD: begin
                  pc_next = pc_reg;
               end
               default: begin
                  pc_next = pc_plus_inc;
               end
            endcase
            // A redirect on the same edge wins over the halt request.
            if (halt_req && !redirect_active)
               state_next = HALT;
         end

         HALT: begin
            if (trap) begin
               pc_next       = trap_vec;
               redirect_next = 1'b1;
               state_next    = RUN;
            end else if (resume) begin
               state_next = RUN;
            end
         end

         default: begin
            state_next = BOOT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= BOOT;
         pc_reg         <= RESET_VEC;
         redirect_reg   <= 1'b0;
         misaligned_reg <= 1'b0;
         bad_addr_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         redirect_reg   <= redirect_next;
         misaligned_reg <= misaligned_next;
         bad_addr_reg   <= bad_addr_next;
      end
   end

   assign pc          = pc_reg;
   assign pc_next_seq = pc_plus_inc;
   assign pc_valid    = (state_reg == RUN);
   assign redirect    = redirect_reg;
   assign misaligned  = misaligned_reg;
   assign bad_addr    = bad_addr_reg;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
// A 32-bit instance covers reset, stall, redirects, priority, alignment and
// halt; an 8-bit instance (RESET_VEC=F8) covers increment wrap-around.
module tb_pc_gen;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, halt_req, resume;
   logic        branch_taken, jump, trap, mret;
   logic [31:0] branch_target, jump_target, trap_vec, epc;
   logic [31:0] pc, pc_next_seq, bad_addr;
   logic        pc_valid, redirect, misaligned;

   logic        rst_n8;
   logic [7:0]  zero8 = 8'h00;
   logic        zero1 = 1'b0;
   logic [7:0]  pc8, pc_next_seq8, bad_addr8;
   logic        pc_valid8, redirect8, misaligned8;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .halt_req      (halt_req),
      .resume        (resume),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .jump          (jump),
      .jump_target   (jump_target),
      .trap          (trap),
      .trap_vec      (trap_vec),
      .mret          (mret),
      .epc           (epc),
      .pc            (pc),
      .pc_next_seq   (pc_next_seq),
      .pc_valid      (pc_valid),
      .redirect      (redirect),
      .misaligned    (misaligned),
      .bad_addr      (bad_addr)
   );

   pc_gen #(
      .DWIDTH     (8),
      .INC        (4),
      .RESET_VEC  (8'hF8),
      .ALIGN_BITS (2)
   ) dut8 (
      .clk           (clk),
      .rst_n         (rst_n8),
      .stall         (zero1),
      .halt_req      (zero1),
      .resume        (zero1),
      .branch_taken  (zero1),
      .branch_target (zero8),
      .jump          (zero1),
      .jump_target   (zero8),
      .trap          (zero1),
      .trap_vec      (zero8),
      .mret          (zero1),
      .epc           (zero8),
      .pc            (pc8),
      .pc_next_seq   (pc_next_seq8),
      .pc_valid      (pc_valid8),
      .redirect      (redirect8),
      .misaligned    (misaligned8),
      .bad_addr      (bad_addr8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      stall = 0; halt_req = 0; resume = 0;
      branch_taken = 0; jump = 0; trap = 0; mret = 0;
      branch_target = '0; jump_target = '0; trap_vec = '0; epc = '0;
   endtask

   initial begin
      rst_n  = 0;
      rst_n8 = 0;
      clear_inputs();

      // Reset held for two edges.
      tick(); tick();
      check("rst_pc",         pc, 0);
      check("rst_valid",      pc_valid, 0);
      check("rst_redirect",   redirect, 0);
      check("rst_misaligned", misaligned, 0);
      check("rst_bad_addr",   bad_addr, 0);

      // BOOT -> RUN, then sequential fetch.
      rst_n = 1;
      tick();
      check("boot_run_pc",    pc, 0);
      check("boot_run_valid", pc_valid, 1);
      tick();
      check("seq_pc4",        pc, 32'h4);
      tick();
      check("seq_pc8",        pc, 32'h8);
      check("seq_next_c",     pc_next_seq, 32'hC);

      // Stall holds pc for three edges.
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_hold", pc, 32'h8);
      end

      // Branch overrides stall.
      branch_taken = 1; branch_target = 32'h40;
      tick();
      check("br_over_stall_pc", pc, 32'h40);
      check("br_redirect",      redirect, 1);
      clear_inputs();
      tick();
      check("br_after_pc",       pc, 32'h44);
      check("br_redirect_clear", redirect, 0);

      // trap beats mret beats jump.
      trap = 1; trap_vec = 32'h100;
      mret = 1; epc      = 32'h200;
      jump = 1; jump_target = 32'h300;
      tick();
      check("prio_trap_pc", pc, 32'h100);
      check("prio_redirect", redirect, 1);
      clear_inputs();
      tick();
      check("prio_after_pc", pc, 32'h104);

      // Misaligned jump is rejected, then trap recovers.
      jump = 1; jump_target = 32'h42;
      tick();
      check("mis_pc_held",  pc, 32'h104);
      check("mis_pulse",    misaligned, 1);
      check("mis_bad_addr", bad_addr, 32'h42);
      check("mis_redirect", redirect, 0);
      clear_inputs();
      trap = 1; trap_vec = 32'h80;
      tick();
      check("mis_trap_pc",     pc, 32'h80);
      check("mis_pulse_clear", misaligned, 0);
      check("mis_bad_hold",    bad_addr, 32'h42);
      check("mis_trap_redir",  redirect, 1);
      clear_inputs();

      // mret to an aligned epc.
      mret = 1; epc = 32'h200;
      tick();
      check("mret_pc", pc, 32'h200);
      clear_inputs();

      // Branch to 0x10, then halt.
      branch_taken = 1; branch_target = 32'h10;
      tick();
      check("br10_pc", pc, 32'h10);
      clear_inputs();
      halt_req = 1;
      tick();
      check("halt_pc",    pc, 32'h10);
      check("halt_valid", pc_valid, 0);
      halt_req = 0;
      tick();
      check("halt_stay_pc", pc, 32'h10);
      resume = 1;
      tick();
      check("resume_valid", pc_valid, 1);
      check("resume_pc",    pc, 32'h10);
      resume = 0;
      tick();
      check("resume_seq_pc", pc, 32'h14);

      // halt_req with a jump on the same edge: jump wins, no halt.
      halt_req = 1; jump = 1; jump_target = 32'h300;
      tick();
      check("haltjmp_pc",    pc, 32'h300);
      check("haltjmp_valid", pc_valid, 1);
      clear_inputs();

      // Trap while halted loads trap_vec and resumes.
      halt_req = 1;
      tick();
      check("halt2_valid", pc_valid, 0);
      halt_req = 0; trap = 1; trap_vec = 32'h80;
      tick();
      check("halt_trap_pc",    pc, 32'h80);
      check("halt_trap_valid", pc_valid, 1);
      clear_inputs();

      // Reset while halted overrides a simultaneous jump.
      halt_req = 1;
      tick();
      check("halt3_pc", pc, 32'h80);
      halt_req = 0;
      rst_n = 0; jump = 1; jump_target = 32'h300;
      tick();
      check("rst_halt_pc",    pc, 0);
      check("rst_halt_valid", pc_valid, 0);
      check("rst_halt_bad",   bad_addr, 0);
      rst_n = 1;
      clear_inputs();
      tick();
      check("rst_halt_run", pc_valid, 1);

      // Misaligned branch (bit 1 set) right out of reset.
      branch_taken = 1; branch_target = 32'h6;
      tick();
      check("misbr_pc",   pc, 32'h0);
      check("misbr_bad",  bad_addr, 32'h6);
      check("misbr_flag", misaligned, 1);
      clear_inputs();

      // 8-bit wrap-around instance.
      check("w_rst_pc",    pc8, 8'hF8);
      check("w_rst_valid", pc_valid8, 0);
      rst_n8 = 1;
      tick();
      check("w_boot_pc", pc8, 8'hF8);
      check("w_valid",   pc_valid8, 1);
      tick();
      check("w_pc_fc",   pc8, 8'hFC);
      check("w_next_00", pc_next_seq8, 8'h00);
      tick();
      check("w_pc_00",   pc8, 8'h00);
      tick();
      check("w_pc_04",   pc8, 8'h04);
      check("w_no_flag", misaligned8, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
